hazard_detect_unit: RTL and testbench

Generates the `stall_lw` and `stall_j` requests consumed by the pipeline stall handler.
- `stall_lw`: load-use hazards, detected from ID-stage source registers against the EX-stage load destination.
- `stall_j`: control redirects (jumps and taken branches resolved in EX).

A small FSM shapes each request into an exact-length pulse, so one hazard produces exactly one stall episode. It sits between the ID/EX pipeline register and the stall handler, on the producer side of the stall-request interface.

---
 rtl/hazard_detect_unit_if.sv | 36 +++
 rtl/hazard_detect_unit.sv | 125 ++++++++++++
 tb/tb_hazard_detect_unit.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/hazard_detect_unit_if.sv
// rtl/hazard_detect_unit_if.sv - stall-request interface between ID/EX pipeline and hazard detector
// Ports (signals):
//   id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2 : ID-stage operand info
//   ex_mem_read, ex_rd, ex_redirect                     : EX-stage load / redirect info
//   stall_lw, stall_j                                   : stall requests to the stall handler
//   lw_stall_cnt, j_stall_cnt                           : performance counters (zero unless enabled)
// Modports: master = pipeline side, slave = hazard_detect_unit.
interface hazard_detect_unit_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_uses_rs1;
    logic                  id_uses_rs2;
    logic                  ex_mem_read;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_redirect;
    logic                  stall_lw;
    logic                  stall_j;
    logic [CNT_W-1:0]      lw_stall_cnt;
    logic [CNT_W-1:0]      j_stall_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        output ex_mem_read, ex_rd, ex_redirect,
        input  stall_lw, stall_j, lw_stall_cnt, j_stall_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        input  ex_mem_read, ex_rd, ex_redirect,
        output stall_lw, stall_j, lw_stall_cnt, j_stall_cnt
    );
endinterface

// File: rtl/hazard_detect_unit.sv
// rtl/hazard_detect_unit.sv - load-use and control-redirect stall request generator
// Purpose: shapes load-use hazards into a 1-cycle stall_lw pulse and EX redirects into a
//          J_BUBBLES-cycle stall_j pulse; the two requests are mutually exclusive.
// Ports:
//   clock   : rising-edge system clock
//   reset_n : asynchronous active-low reset (also forces both stall outputs low)
//   hz      : hazard_detect_unit_if.slave (ID/EX inputs, stall outputs, counters)
// Optional feature: define HAZARD_PERF_CNT_EN to build the saturating stall-cycle counters.
module hazard_detect_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int J_BUBBLES  = 2,
    parameter int CNT_W      = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    hazard_detect_unit_if.slave   hz
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_LW_HOLD = 2'd1;
    localparam logic [1:0] ST_J_STALL = 2'd2;

    localparam logic [2:0] J_LOAD = 3'(J_BUBBLES - 1);

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [2:0]            r_jcnt;
    logic [2:0]            w_jcnt_nxt;
    logic                  w_lu_hit;
    logic                  w_lw_req;
    logic                  w_j_req;
    logic                  w_stall_lw;
    logic                  w_stall_j;
    logic [REG_ADDR_W-1:0] w_ex_rd;
    logic [REG_ADDR_W-1:0] w_id_rs1;
    logic [REG_ADDR_W-1:0] w_id_rs2;

    assign w_ex_rd  = hz.ex_rd;
    assign w_id_rs1 = hz.id_rs1;
    assign w_id_rs2 = hz.id_rs2;

    // x0 is hardwired zero, so a load targeting it never creates a dependency.
    assign w_lu_hit = hz.id_valid & hz.ex_mem_read & (w_ex_rd != '0) &
                      ((hz.id_uses_rs1 & (w_id_rs1 == w_ex_rd)) |
                       (hz.id_uses_rs2 & (w_id_rs2 == w_ex_rd)));

    always_comb begin
        w_state_nxt = r_state;
        w_jcnt_nxt  = r_jcnt;
        w_lw_req    = 1'b0;
        w_j_req     = 1'b0;
        case (r_state)
            ST_IDLE, ST_LW_HOLD: begin
                // Redirect outranks load-use: the dependent instruction is squashed anyway.
                if (hz.ex_redirect) begin
                    w_j_req     = 1'b1;
                    w_jcnt_nxt  = J_LOAD;
                    w_state_nxt = (J_BUBBLES == 1) ? ST_IDLE : ST_J_STALL;
                end else if ((r_state == ST_IDLE) && w_lu_hit) begin
                    // LW_HOLD masks lu_hit: the bubble inserted last cycle now sits in EX.
                    w_lw_req    = 1'b1;
                    w_state_nxt = ST_LW_HOLD;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_J_STALL: begin
                // Inputs ignored here; the instructions that produced them are being flushed.
                w_j_req    = 1'b1;
                w_jcnt_nxt = r_jcnt - 3'd1;
                if (r_jcnt <= 3'd1) begin
                    w_jcnt_nxt  = 3'd0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_jcnt_nxt  = 3'd0;
            end
        endcase
    end

    // Requests are Mealy on the first cycle, so gate with reset_n to drop them
    // immediately when reset asserts rather than at the next edge.
    assign w_stall_lw = w_lw_req & reset_n;
    assign w_stall_j  = w_j_req & reset_n;
    assign hz.stall_lw = w_stall_lw;
    assign hz.stall_j  = w_stall_j;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_jcnt  <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_jcnt  <= w_jcnt_nxt;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] r_lw_cnt;
    logic [CNT_W-1:0] r_j_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_lw_cnt <= '0;
            r_j_cnt  <= '0;
        end else begin
            if (w_stall_lw && (r_lw_cnt != {CNT_W{1'b1}})) begin
                r_lw_cnt <= r_lw_cnt + 1'b1;
            end
            if (w_stall_j && (r_j_cnt != {CNT_W{1'b1}})) begin
                r_j_cnt <= r_j_cnt + 1'b1;
            end
        end
    end

    assign hz.lw_stall_cnt = r_lw_cnt;
    assign hz.j_stall_cnt  = r_j_cnt;
`else
    assign hz.lw_stall_cnt = {CNT_W{1'b0}};
    assign hz.j_stall_cnt  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_detect_unit.sv
// tb/tb_hazard_detect_unit.sv - directed self-checking bench for hazard_detect_unit
module tb_hazard_detect_unit;

    localparam int REG_ADDR_W = 5;
    localparam int J_BUBBLES  = 2;
    localparam int CNT_W      = 32;
`ifdef HAZARD_PERF_CNT_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    logic clock;
    logic reset_n;
    int   n_vec;
    int   n_err;

    hazard_detect_unit_if #(.REG_ADDR_W(REG_ADDR_W), .CNT_W(CNT_W)) hz_if ();

    hazard_detect_unit #(
        .REG_ADDR_W (REG_ADDR_W),
        .J_BUBBLES  (J_BUBBLES),
        .CNT_W      (CNT_W)
    ) u_dut (
        .clock   (clock),
        .reset_n (reset_n),
        .hz      (hz_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are changed.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2,
                          input logic mr, input logic [4:0] rd, input logic rdr);
        hz_if.id_valid    = v;
        hz_if.id_rs1      = rs1;
        hz_if.id_uses_rs1 = u1;
        hz_if.id_rs2      = rs2;
        hz_if.id_uses_rs2 = u2;
        hz_if.ex_mem_read = mr;
        hz_if.ex_rd       = rd;
        hz_if.ex_redirect = rdr;
    endtask

    task automatic chk_out(input string tag, input logic lw, input logic j);
        chk({tag, ".lw"}, 32'(hz_if.stall_lw), 32'(lw));
        chk({tag, ".j"},  32'(hz_if.stall_j),  32'(j));
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        reset_n = 1'b0;
        // Reset state: a live hazard and a redirect must not leak through while in reset.
        set_in(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1);
        @(negedge clock);
        chk_out("rst", 1'b0, 1'b0);
        chk("rst.lwcnt", hz_if.lw_stall_cnt, 32'd0);
        chk("rst.jcnt",  hz_if.j_stall_cnt,  32'd0);
        tick();
        hz_if.ex_redirect = 1'b0;
        reset_n = 1'b1;

        // 1: held load-use hazard -> 1, 0, 1
        @(negedge clock); chk_out("lu.c0", 1'b1, 1'b0);
        tick();
        @(negedge clock); chk_out("lu.c1", 1'b0, 1'b0);
        tick();
        @(negedge clock); chk_out("lu.c2", 1'b1, 1'b0);
        tick();
        hz_if.id_valid = 1'b0;
        @(negedge clock); chk_out("lu.c3", 1'b0, 1'b0);
        tick();

        // 2: x0 and masked/non-load cases never stall
        set_in(1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0);
        @(negedge clock); chk_out("x0.a", 1'b0, 1'b0);
        tick();
        @(negedge clock); chk_out("x0.b", 1'b0, 1'b0);
        tick();
        set_in(1'b1, 5'd0, 1'b0, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0);
        @(negedge clock); chk_out("nouse", 1'b0, 1'b0);
        tick();
        set_in(1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 5'd9, 1'b0);
        @(negedge clock); chk_out("noload", 1'b0, 1'b0);
        tick();
        set_in(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);

        // 3: redirect pulse -> exactly 2 stall_j cycles, second redirect ignored
        hz_if.ex_redirect = 1'b1;
        @(negedge clock); chk_out("j.c0", 1'b0, 1'b1);
        tick();
        @(negedge clock); chk_out("j.c1", 1'b0, 1'b1);
        tick();
        hz_if.ex_redirect = 1'b0;
        @(negedge clock); chk_out("j.c2", 1'b0, 1'b0);
        tick();
        @(negedge clock); chk_out("j.c3", 1'b0, 1'b0);
        chk("cnt.lw", hz_if.lw_stall_cnt, 32'(2 * PERF));
        chk("cnt.j",  hz_if.j_stall_cnt,  32'(2 * PERF));
        tick();

        // 4: redirect and load-use together -> redirect wins, no stall_lw in J_STALL
        set_in(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1);
        @(negedge clock); chk_out("pri.c0", 1'b0, 1'b1);
        tick();
        hz_if.ex_redirect = 1'b0;
        @(negedge clock); chk_out("pri.c1", 1'b0, 1'b1);
        tick();
        hz_if.id_valid = 1'b0;
        @(negedge clock); chk_out("pri.c2", 1'b0, 1'b0);
        tick();

        // 5: reset mid-J_STALL drops stall_j without a clock edge
        hz_if.ex_redirect = 1'b1;
        @(negedge clock); chk_out("rj.c0", 1'b0, 1'b1);
        tick();
        hz_if.ex_redirect = 1'b0;
        @(negedge clock); chk_out("rj.c1", 1'b0, 1'b1);
        #1 reset_n = 1'b0;
        #1;
        chk_out("rj.async", 1'b0, 1'b0);
        chk("rj.lwcnt", hz_if.lw_stall_cnt, 32'd0);
        chk("rj.jcnt",  hz_if.j_stall_cnt,  32'd0);
        tick();
        reset_n = 1'b1;
        @(negedge clock); chk_out("rj.post0", 1'b0, 1'b0);
        tick();
        @(negedge clock); chk_out("rj.post1", 1'b0, 1'b0);
        tick();
        set_in(1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b1, 5'd12, 1'b0);
        @(negedge clock); chk_out("rj.new", 1'b1, 1'b0);
        tick();
        hz_if.id_valid = 1'b0;
        @(negedge clock);
        chk_out("rj.end", 1'b0, 1'b0);
        chk("end.lw", hz_if.lw_stall_cnt, 32'(PERF));
        chk("end.j",  hz_if.j_stall_cnt,  32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
